debug_hart_ctrl: RTL and testbench
==================================

// Module: debug_hart_ctrl
// PURPOSE
// - Hart-side responder for debug_dm: consumes O_HALTREQ/O_RESUMEREQ/O_HARTRESET and AR_* abstract-register
//   accesses; drives I_HALTED/I_RUNNING/I_RESUMEACK/I_HAVERESET and AR read data.
// - Sits between debug_dm and the CPU pipeline. Stalls/redirects the core and owns dcsr/dpc/dscratch.
//   Reaches GPRs through a register-file side port.
// PARAMETERS
// - MISA_VALUE   32'h4000_1105  read-only value returned for AR_AD 16'h0301
// - HARTID       32'd0          read-only value returned for AR_AD 16'h0F14 (mhartid)
// - RESET_HALT   1'b0           1: leave hart reset directly in HALTED (dcsr.cause=3'd5)
// PORTS
// - CLK            in   1   single clock
// - RST_N          in   1   asynchronous, active-low reset
// - I_HALTREQ      in   1   level halt request from DM
// - I_RESUMEREQ    in   1   level resume request from DM; held until O_RESUMEACK is seen
// - I_HARTRESET    in   1   level hart reset from DM
// - I_ACKHAVERESET in   1   pulse; clears O_HAVERESET
// - O_HALTED       out  1   hart halted in debug mode
// - O_RUNNING      out  1   hart running (state RUNNING only)
// - O_RESUMEACK    out  1   resume completed; held until I_RESUMEREQ drops
// - O_HAVERESET    out  1   sticky, set by hart reset
// - AR_EN          in   1   abstract register access strobe (1 cycle)
// - AR_WR          in   1   1=write, 0=read
// - AR_AD          in   16  regno: 0x1000-0x101F GPR; 0x07B0 dcsr, 0x07B1 dpc, 0x07B2/3 dscratch0/1
// - AR_WD          in   32  write data from DM
// - AR_RD          out  32  registered read data
// - CORE_STALL     out  1   request pipeline freeze
// - CORE_IDLE      in   1   pipeline drained, no instruction in flight
// - CORE_PC        in   32  PC of next instruction to execute
// - CORE_EBREAK    in   1   ebreak retiring this cycle (M-mode)
// - CORE_RETIRE    in   1   an instruction retired this cycle
// - CORE_RESUME    out  1   1-cycle pulse: restart fetch at CORE_RESUME_PC
// - CORE_RESUME_PC out  32  = dpc
// - CORE_RESET     out  1   hart reset to core (= I_HARTRESET, combinational)
// - RF_AD          out  5   = AR_AD[4:0] (combinational)
// - RF_WE          out  1   GPR write strobe
// - RF_WD          out  32  = AR_WD
// - RF_RD          in   32  GPR read data, combinational from RF_AD
// BEHAVIOUR
// - Reset: state RUNNING (HALTED if RESET_HALT). All outputs 0 except O_RUNNING=1 (O_HALTED=1 if RESET_HALT).
//   dpc=0; dscratch*=0; dcsr={4'd4,12'd0,ebreakm=0,6'd0,cause=0,3'd0,step=0,prv=2'b11}.
// - FSM RUNNING->HALTING on I_HALTREQ (cause=3), on CORE_EBREAK with dcsr.ebreakm (cause=1),
//   or on the first CORE_RETIRE after resume with dcsr.step (cause=4). Priority: ebreak > step > haltreq.
// - HALTING: CORE_STALL=1. When CORE_IDLE: dpc<=CORE_PC (ebreak: PC of the ebreak), then ->HALTED
//   next edge. Minimum latency haltreq->O_HALTED is 2 cycles.
// - HALTED: CORE_STALL=1, O_HALTED=1.
//   - I_RESUMEREQ & !I_HALTREQ & !O_RESUMEACK -> RESUMING.
//   - haltreq and resumereq together: stay HALTED.
// - RESUMING (1 cycle): CORE_RESUME=1, CORE_STALL=1. Next edge: ->RUNNING, O_RESUMEACK<=1.
//   O_RESUMEACK clears the cycle after I_RESUMEREQ is sampled low.
// - I_HARTRESET overrides all states:
//   - while high: CORE_RESET=1, FSM forced to reset state, CSRs reset, O_HAVERESET<=1.
//   - I_ACKHAVERESET clears it, except in a cycle where I_HARTRESET=1.
// - AR access is honored only in HALTED.
//   - read: AR_RD<=selected value on the AR_EN edge; held until the next read.
//   - write: commits on the AR_EN edge. GPR writes pulse RF_WE for that same cycle; x0 writes are dropped.
//   - dcsr: only ebreakm[15] and step[2] are writable. dpc bit0 always reads 0.
//   - misa/mhartid are read-only.
//   - unmapped regno, or any state other than HALTED: reads return 0, writes ignored, RF_WE=0.
// - AR_RD resets to 0; the hart-reset path does not clear it.
// STRUCTURE
// - debug_pkg: FSM state enum (RUNNING/HALTING/HALTED/RESUMING), regno constants, dcsr cause codes,
//   dcsr field offsets.
// - Sub-module debug_hart_csr: dcsr/dpc/dscratch storage, write masking, read mux.
//   FSM, handshakes and RF port stay in top.
// TESTING
// 1. haltreq with CORE_IDLE tied 1 and CORE_PC=0x8000_0010 -> O_HALTED=1 at cycle 2; dpc=0x8000_0010;
//    dcsr.cause=3.
// 2. Halted, AR read 0x0301 -> AR_RD=0x4000_1105. AR write 0x1005=0xDEAD_BEEF -> RF_WE=1, RF_AD=5.
//    AR write 0x1000 -> no RF_WE.
// 3. Halted, resumereq -> CORE_RESUME pulse with CORE_RESUME_PC=dpc, O_RUNNING=1, O_RESUMEACK=1
//    until resumereq drops.
// 4. dcsr write step=1, resume, one CORE_RETIRE -> re-halt with cause=4. ebreakm=1 plus CORE_EBREAK
//    -> cause=1.
// 5. Hartreset asserted mid-HALTING -> CORE_RESET=1, O_RUNNING=1 (RESET_HALT=0), O_HAVERESET=1
//    until I_ACKHAVERESET.
// 6. AR access while running, and to regno 0x0C00 -> AR_RD=0, no state change.

Source files
------------

// File: rtl/debug_pkg.sv
// debug_pkg: shared state encoding, abstract-register numbers and dcsr layout for the hart debug block.
package debug_pkg;
  typedef enum logic [1:0] {ST_RUNNING, ST_HALTING, ST_HALTED, ST_RESUMING} hart_state_e;
  localparam logic [15:0] REG_MISA      = 16'h0301;
  localparam logic [15:0] REG_MHARTID   = 16'h0F14;
  localparam logic [15:0] REG_DCSR      = 16'h07B0;
  localparam logic [15:0] REG_DPC       = 16'h07B1;
  localparam logic [15:0] REG_DSCRATCH0 = 16'h07B2;
  localparam logic [15:0] REG_DSCRATCH1 = 16'h07B3;
  localparam logic [15:0] REG_GPR0      = 16'h1000;
  localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
  localparam logic [2:0] CAUSE_STEP      = 3'd4;
  localparam logic [2:0] CAUSE_RESETHALT = 3'd5;
  localparam int DCSR_EBREAKM = 15;
  localparam int DCSR_STEP    = 2;
  function automatic logic is_gpr(input logic [15:0] ad);
    return ad[15:5] == REG_GPR0[15:5];
  endfunction
endpackage

// File: rtl/debug_hart_csr.sv
// debug_hart_csr: dcsr/dpc/dscratch storage with write masking and read mux.
module debug_hart_csr import debug_pkg::*; #(
  parameter logic RESET_HALT = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        clr,
  input  logic        we,
  input  logic [15:0] ad,
  input  logic [31:0] wd,
  input  logic        cause_set,
  input  logic [2:0]  cause,
  input  logic        dpc_set,
  input  logic [31:0] pc,
  output logic [31:0] rd,
  output logic [31:0] dpc,
  output logic        step,
  output logic        ebreakm
);
  localparam logic [2:0] RST_CAUSE = RESET_HALT ? CAUSE_RESETHALT : 3'd0;
  logic [2:0]  cause_q;
  logic [31:0] dpc_q, scr0, scr1, dcsr;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ebreakm <= 1'b0;
      step    <= 1'b0;
      cause_q <= RST_CAUSE;
      dpc_q   <= '0;
      scr0    <= '0;
      scr1    <= '0;
    end else if (clr) begin
      ebreakm <= 1'b0;
      step    <= 1'b0;
      cause_q <= RST_CAUSE;
      dpc_q   <= '0;
      scr0    <= '0;
      scr1    <= '0;
    end else begin
      if (cause_set) cause_q <= cause;
      if (dpc_set) dpc_q <= pc;
      else if (we && ad == REG_DPC) dpc_q <= wd;
      if (we && ad == REG_DCSR) begin
        ebreakm <= wd[DCSR_EBREAKM];
        step    <= wd[DCSR_STEP];
      end
      if (we && ad == REG_DSCRATCH0) scr0 <= wd;
      if (we && ad == REG_DSCRATCH1) scr1 <= wd;
    end
  end
  // dpc is always halfword aligned on the way out
  assign dpc  = dpc_q & ~32'd1;
  assign dcsr = {4'd4, 12'd0, ebreakm, 6'd0, cause_q, 3'd0, step, 2'b11};
  assign rd   = ad == REG_DCSR      ? dcsr :
                ad == REG_DPC       ? dpc  :
                ad == REG_DSCRATCH0 ? scr0 :
                ad == REG_DSCRATCH1 ? scr1 : '0;
endmodule

// File: rtl/debug_hart_ctrl.sv
// debug_hart_ctrl: hart-side debug responder; halt/resume FSM, DM handshakes and GPR side port.
module debug_hart_ctrl import debug_pkg::*; #(
  parameter logic [31:0] MISA_VALUE = 32'h4000_1105,
  parameter logic [31:0] HARTID     = 32'd0,
  parameter logic        RESET_HALT = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        I_HALTREQ,
  input  logic        I_RESUMEREQ,
  input  logic        I_HARTRESET,
  input  logic        I_ACKHAVERESET,
  output logic        O_HALTED,
  output logic        O_RUNNING,
  output logic        O_RESUMEACK,
  output logic        O_HAVERESET,
  input  logic        AR_EN,
  input  logic        AR_WR,
  input  logic [15:0] AR_AD,
  input  logic [31:0] AR_WD,
  output logic [31:0] AR_RD,
  output logic        CORE_STALL,
  input  logic        CORE_IDLE,
  input  logic [31:0] CORE_PC,
  input  logic        CORE_EBREAK,
  input  logic        CORE_RETIRE,
  output logic        CORE_RESUME,
  output logic [31:0] CORE_RESUME_PC,
  output logic        CORE_RESET,
  output logic [4:0]  RF_AD,
  output logic        RF_WE,
  output logic [31:0] RF_WD,
  input  logic [31:0] RF_RD
);
  localparam hart_state_e RST_ST = RESET_HALT ? ST_HALTED : ST_RUNNING;
  hart_state_e state, state_nx;
  logic        halted, brk, stp, go_halt, ar_wr;
  logic [2:0]  cause_nx;
  logic [31:0] csr_rd, ar_val;
  logic        step, ebreakm;
  assign halted   = state == ST_HALTED;
  assign brk      = CORE_EBREAK && ebreakm;
  assign stp      = CORE_RETIRE && step;
  assign go_halt  = state == ST_RUNNING && (brk || stp || I_HALTREQ);
  assign cause_nx = brk ? CAUSE_EBREAK : stp ? CAUSE_STEP : CAUSE_HALTREQ;
  assign ar_wr    = AR_EN && AR_WR && halted;
  always_comb begin
    state_nx    = state;
    O_HALTED    = 1'b0;
    O_RUNNING   = 1'b0;
    CORE_STALL  = 1'b1;
    CORE_RESUME = 1'b0;
    case (state)
      ST_RUNNING: begin
        O_RUNNING  = 1'b1;
        CORE_STALL = 1'b0;
        if (go_halt) state_nx = ST_HALTING;
      end
      ST_HALTING: if (CORE_IDLE) state_nx = ST_HALTED;
      ST_HALTED: begin
        O_HALTED = 1'b1;
        if (I_RESUMEREQ && !I_HALTREQ && !O_RESUMEACK) state_nx = ST_RESUMING;
      end
      default: begin
        CORE_RESUME = 1'b1;
        state_nx    = ST_RUNNING;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= RST_ST;
      O_RESUMEACK <= 1'b0;
      O_HAVERESET <= 1'b0;
      AR_RD       <= '0;
    end else begin
      state       <= I_HARTRESET ? RST_ST : state_nx;
      O_RESUMEACK <= state == ST_RESUMING || (O_RESUMEACK && I_RESUMEREQ);
      O_HAVERESET <= I_HARTRESET || (O_HAVERESET && !I_ACKHAVERESET);
      if (AR_EN && !AR_WR) AR_RD <= ar_val;
    end
  end
  // anything outside HALTED reads as zero, mapped or not
  assign ar_val = !halted                ? '0         :
                  AR_AD == REG_MISA      ? MISA_VALUE :
                  AR_AD == REG_MHARTID   ? HARTID     :
                  is_gpr(AR_AD)          ? RF_RD      : csr_rd;
  assign CORE_RESET = I_HARTRESET;
  assign RF_AD      = AR_AD[4:0];
  assign RF_WD      = AR_WD;
  assign RF_WE      = ar_wr && is_gpr(AR_AD) && |AR_AD[4:0];
  debug_hart_csr #(.RESET_HALT(RESET_HALT)) u_csr (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (I_HARTRESET),
    .we        (ar_wr),
    .ad        (AR_AD),
    .wd        (AR_WD),
    .cause_set (go_halt),
    .cause     (cause_nx),
    .dpc_set   (state == ST_HALTING && CORE_IDLE),
    .pc        (CORE_PC),
    .rd        (csr_rd),
    .dpc       (CORE_RESUME_PC),
    .step      (step),
    .ebreakm   (ebreakm)
  );
endmodule

// File: tb/tb_debug_hart_ctrl.sv
// tb_debug_hart_ctrl: directed vector table plus hand sequences for step, ebreak and hart reset.
module tb_debug_hart_ctrl;
  logic        CLK, RST_N;
  logic        I_HALTREQ, I_RESUMEREQ, I_HARTRESET, I_ACKHAVERESET;
  logic        O_HALTED, O_RUNNING, O_RESUMEACK, O_HAVERESET;
  logic        AR_EN, AR_WR;
  logic [15:0] AR_AD;
  logic [31:0] AR_WD, AR_RD;
  logic        CORE_STALL, CORE_IDLE, CORE_EBREAK, CORE_RETIRE, CORE_RESUME, CORE_RESET;
  logic [31:0] CORE_PC, CORE_RESUME_PC;
  logic [4:0]  RF_AD;
  logic        RF_WE;
  logic [31:0] RF_WD, RF_RD;
  int n_cmp = 0;
  int n_err = 0;
  localparam logic [31:0] P0 = 32'h8000_0010;
  localparam logic [31:0] P1 = 32'h8000_0100;

  debug_hart_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .I_HALTREQ(I_HALTREQ), .I_RESUMEREQ(I_RESUMEREQ), .I_HARTRESET(I_HARTRESET),
    .I_ACKHAVERESET(I_ACKHAVERESET),
    .O_HALTED(O_HALTED), .O_RUNNING(O_RUNNING), .O_RESUMEACK(O_RESUMEACK), .O_HAVERESET(O_HAVERESET),
    .AR_EN(AR_EN), .AR_WR(AR_WR), .AR_AD(AR_AD), .AR_WD(AR_WD), .AR_RD(AR_RD),
    .CORE_STALL(CORE_STALL), .CORE_IDLE(CORE_IDLE), .CORE_PC(CORE_PC),
    .CORE_EBREAK(CORE_EBREAK), .CORE_RETIRE(CORE_RETIRE),
    .CORE_RESUME(CORE_RESUME), .CORE_RESUME_PC(CORE_RESUME_PC), .CORE_RESET(CORE_RESET),
    .RF_AD(RF_AD), .RF_WE(RF_WE), .RF_WD(RF_WD), .RF_RD(RF_RD)
  );

  // register file stand-in: each GPR reads back a recognisable pattern
  assign RF_RD = 32'h1234_0000 | {27'd0, RF_AD};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        hreq, rreq, en, wr;
    logic [15:0] ad;
    logic [31:0] wd;
    logic        halted, running, rack, stall, resume, rf_we;
    logic [31:0] rd, pc;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic hreq, rreq, en, wr, input logic [15:0] ad, input logic [31:0] wd,
                     input logic halted, running, rack, stall, resume, rf_we,
                     input logic [31:0] rd, pc);
    vec_t v;
    v.hreq = hreq; v.rreq = rreq; v.en = en; v.wr = wr; v.ad = ad; v.wd = wd;
    v.halted = halted; v.running = running; v.rack = rack; v.stall = stall;
    v.resume = resume; v.rf_we = rf_we; v.rd = rd; v.pc = pc;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ar(input logic wr, input logic [15:0] ad, input logic [31:0] wd);
    AR_EN = 1'b1; AR_WR = wr; AR_AD = ad; AR_WD = wd;
    tick();
    AR_EN = 1'b0; AR_WR = 1'b0;
  endtask

  task automatic resume_run();
    I_RESUMEREQ = 1'b1;
    tick();
    tick();
    I_RESUMEREQ = 1'b0;
    tick();
  endtask

  initial begin
    RST_N = 1'b0; I_HALTREQ = 0; I_RESUMEREQ = 0; I_HARTRESET = 0; I_ACKHAVERESET = 0;
    AR_EN = 0; AR_WR = 0; AR_AD = '0; AR_WD = '0;
    CORE_IDLE = 1; CORE_PC = P0; CORE_EBREAK = 0; CORE_RETIRE = 0;
    //   hq rq en wr ad         wd             hl rn ak st rs we rd             pc
    add(1, 0, 0, 0, 16'h0000, 32'h0,         0, 0, 0, 1, 0, 0, 32'h0,         32'h0);
    add(1, 0, 0, 0, 16'h0000, 32'h0,         1, 0, 0, 1, 0, 0, 32'h0,         P0);
    add(0, 0, 1, 0, 16'h0301, 32'h0,         1, 0, 0, 1, 0, 0, 32'h4000_1105, P0);
    add(0, 0, 1, 0, 16'h07B1, 32'h0,         1, 0, 0, 1, 0, 0, P0,            P0);
    add(0, 0, 1, 0, 16'h07B0, 32'h0,         1, 0, 0, 1, 0, 0, 32'h4000_00C3, P0);
    add(0, 0, 1, 1, 16'h1005, 32'hDEAD_BEEF, 1, 0, 0, 1, 0, 1, 32'h4000_00C3, P0);
    add(0, 0, 1, 1, 16'h1000, 32'h1111_1111, 1, 0, 0, 1, 0, 0, 32'h4000_00C3, P0);
    add(0, 0, 1, 0, 16'h1007, 32'h0,         1, 0, 0, 1, 0, 0, 32'h1234_0007, P0);
    add(0, 0, 1, 1, 16'h07B2, 32'hCAFE_F00D, 1, 0, 0, 1, 0, 0, 32'h1234_0007, P0);
    add(0, 0, 1, 0, 16'h07B2, 32'h0,         1, 0, 0, 1, 0, 0, 32'hCAFE_F00D, P0);
    add(0, 0, 1, 1, 16'h07B1, 32'h8000_0101, 1, 0, 0, 1, 0, 0, 32'hCAFE_F00D, P1);
    add(0, 0, 1, 0, 16'h07B1, 32'h0,         1, 0, 0, 1, 0, 0, P1,            P1);
    add(0, 0, 1, 0, 16'h0C00, 32'h0,         1, 0, 0, 1, 0, 0, 32'h0,         P1);
    add(0, 0, 1, 0, 16'h0F14, 32'h0,         1, 0, 0, 1, 0, 0, 32'h0,         P1);
    add(0, 1, 0, 0, 16'h0000, 32'h0,         0, 0, 0, 1, 1, 0, 32'h0,         P1);
    add(0, 1, 0, 0, 16'h0000, 32'h0,         0, 1, 1, 0, 0, 0, 32'h0,         P1);
    add(0, 1, 0, 0, 16'h0000, 32'h0,         0, 1, 1, 0, 0, 0, 32'h0,         P1);
    add(0, 0, 0, 0, 16'h0000, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0,         P1);
    add(0, 0, 1, 0, 16'h0301, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0,         P1);
    add(0, 0, 1, 1, 16'h07B0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0, 32'h0,         P1);
    add(0, 0, 1, 1, 16'h1003, 32'h5555_5555, 0, 1, 0, 0, 0, 0, 32'h0,         P1);
    add(1, 0, 0, 0, 16'h0000, 32'h0,         0, 0, 0, 1, 0, 0, 32'h0,         P1);
    add(1, 0, 0, 0, 16'h0000, 32'h0,         1, 0, 0, 1, 0, 0, 32'h0,         P0);
    add(0, 0, 1, 0, 16'h07B0, 32'h0,         1, 0, 0, 1, 0, 0, 32'h4000_00C3, P0);
    add(0, 0, 1, 1, 16'h07B0, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 0, 32'h4000_00C3, P0);
    add(0, 0, 1, 0, 16'h07B0, 32'h0,         1, 0, 0, 1, 0, 0, 32'h4000_80C7, P0);

    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    #1;
    chk("rst_running", 0, O_RUNNING, 1);
    chk("rst_halted", 0, O_HALTED, 0);
    chk("rst_stall", 0, CORE_STALL, 0);
    chk("rst_havereset", 0, O_HAVERESET, 0);
    chk("rst_resumeack", 0, O_RESUMEACK, 0);
    chk("rst_ar_rd", 0, AR_RD, 0);
    chk("rst_resume_pc", 0, CORE_RESUME_PC, 0);

    for (int i = 0; i < vt.size(); i++) begin
      I_HALTREQ = vt[i].hreq; I_RESUMEREQ = vt[i].rreq;
      AR_EN = vt[i].en; AR_WR = vt[i].wr; AR_AD = vt[i].ad; AR_WD = vt[i].wd;
      tick();
      chk("halted", i, O_HALTED, vt[i].halted);
      chk("running", i, O_RUNNING, vt[i].running);
      chk("resumeack", i, O_RESUMEACK, vt[i].rack);
      chk("stall", i, CORE_STALL, vt[i].stall);
      chk("core_resume", i, CORE_RESUME, vt[i].resume);
      chk("rf_we", i, RF_WE, vt[i].rf_we);
      chk("ar_rd", i, AR_RD, vt[i].rd);
      chk("resume_pc", i, CORE_RESUME_PC, vt[i].pc);
      if (vt[i].rf_we) begin
        chk("rf_ad", i, RF_AD, {27'd0, vt[i].ad[4:0]});
        chk("rf_wd", i, RF_WD, vt[i].wd);
      end
    end
    I_HALTREQ = 0; I_RESUMEREQ = 0; AR_EN = 0; AR_WR = 0;

    // single step: first retire after resume re-halts with cause 4
    I_RESUMEREQ = 1'b1;
    tick();
    chk("step_resume_pulse", 100, CORE_RESUME, 1);
    tick();
    chk("step_running", 101, O_RUNNING, 1);
    I_RESUMEREQ = 1'b0; CORE_RETIRE = 1'b1;
    tick();
    CORE_RETIRE = 1'b0;
    chk("step_halting", 102, {O_RUNNING, CORE_STALL}, 32'd1);
    chk("step_ack_clear", 102, O_RESUMEACK, 0);
    tick();
    chk("step_halted", 103, O_HALTED, 1);
    ar(1'b0, 16'h07B0, 32'h0);
    chk("step_cause", 104, AR_RD, 32'h4000_8107);

    // ebreak and retire together: ebreak wins, dpc is the ebreak PC
    resume_run();
    chk("brk_running", 110, O_RUNNING, 1);
    CORE_PC = 32'h8000_0200; CORE_EBREAK = 1'b1; CORE_RETIRE = 1'b1;
    tick();
    CORE_EBREAK = 1'b0; CORE_RETIRE = 1'b0;
    tick();
    chk("brk_halted", 111, O_HALTED, 1);
    chk("brk_dpc", 111, CORE_RESUME_PC, 32'h8000_0200);
    ar(1'b0, 16'h07B0, 32'h0);
    chk("brk_cause", 112, AR_RD, 32'h4000_8047);

    // hart reset while stuck in HALTING
    CORE_PC = P0;
    resume_run();
    CORE_IDLE = 1'b0; I_HALTREQ = 1'b1;
    tick();
    tick();
    chk("hr_halting", 120, {O_HALTED, CORE_STALL}, 32'd1);
    I_HARTRESET = 1'b1;
    #1;
    chk("hr_core_reset", 121, CORE_RESET, 1);
    tick();
    chk("hr_running", 122, O_RUNNING, 1);
    chk("hr_havereset", 122, O_HAVERESET, 1);
    chk("hr_stall", 122, CORE_STALL, 0);
    I_ACKHAVERESET = 1'b1;
    tick();
    chk("hr_ack_blocked", 123, O_HAVERESET, 1);
    I_HARTRESET = 0; I_ACKHAVERESET = 0; I_HALTREQ = 0; CORE_IDLE = 1;
    #1;
    chk("hr_core_reset_off", 124, CORE_RESET, 0);
    tick();
    chk("hr_sticky", 125, O_HAVERESET, 1);
    chk("hr_ar_rd_kept", 125, AR_RD, 32'h4000_8047);
    I_ACKHAVERESET = 1'b1;
    tick();
    I_ACKHAVERESET = 1'b0;
    chk("hr_ack_clear", 126, O_HAVERESET, 0);
    I_HALTREQ = 1'b1;
    tick();
    tick();
    I_HALTREQ = 1'b0;
    chk("hr_rehalted", 127, O_HALTED, 1);
    ar(1'b0, 16'h07B0, 32'h0);
    chk("hr_dcsr_reset", 128, AR_RD, 32'h4000_00C3);
    ar(1'b0, 16'h07B2, 32'h0);
    chk("hr_dscratch_reset", 129, AR_RD, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
